sequential_divider: RTL and testbench
=====================================

# sequential_divider

Multi-cycle restoring divider: the inverse of the adder path, built from repeated trial subtraction, one quotient bit per clock. Sits beside the ALU's combinational adder/subtractor and serves the CPU's `div` instruction. The control unit stalls on `busy` and latches HI/LO from `remainder`/`quotient` on `done`.

## Interface
- `BITS`, default 32: operand, quotient and remainder width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only when `busy`=0.
- `dividend`  in  BITS  numerator, captured at the accepting edge.
- `divisor`  in  BITS  denominator, captured at the accepting edge.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse: results are valid.
- `quotient`  out  BITS  registered result.
- `remainder`  out  BITS  registered result.
- `div_by_zero`  out  1  registered with the results; high if the captured divisor was 0.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1. Iteration counter runs 0..BITS-1.
  - IDLE is re-entered with `done`=1 for one cycle.
- IDLE → RUN at the edge where `start`=1:
  - Captures operands (as magnitudes when signed).
  - Partial remainder := 0. Quotient shift register := dividend magnitude. Counter := 0.
- Each RUN edge:
  - Shift {partial remainder, quotient} left by 1.
  - Form the BITS+1-bit trial difference: partial remainder minus divisor.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- RUN → IDLE at the edge completing iteration BITS-1:
  - Writes `quotient`, `remainder` and `div_by_zero`.
  - Asserts `done`.
  - Applies the sign fix-up when signed.
- `start` while `busy`=1: ignored, with no effect on state or outputs.
- `start`=1 in the `done` cycle: accepted, since `busy`=0 there. `done` drops and `busy` rises at the same edge.
- Divisor 0: runs the full latency with no special path.
  - Natural result: `quotient`=all ones, `remainder`=dividend, `div_by_zero`=1.
  - No sign fix-up is applied to a divide-by-zero result.
- Outputs hold their last values until the next completion or `clear`.
- `clear`:
  - Forces IDLE.
  - Clears `busy`, `done`, `quotient`, `remainder`, `div_by_zero` and the counter to 0.
  - If asserted mid-RUN, aborts the operation; no `done` is produced.
  - Takes priority over `start`.

## Timing
- Reset values: all outputs 0.
- Acceptance at edge k. `busy` is high for the BITS cycles following edges k..k+BITS-1.
- At edge k+BITS: results are written, `busy`=0, `done`=1 for exactly one cycle.
- Latency from the accepting edge to `done`: BITS clocks (32 at default).
- Throughput: one division per BITS clocks with back-to-back `start`.
- No combinational path from inputs to outputs.

## Configuration
- Macro `SEQUENTIAL_DIVIDER_SIGNED_EN`.
- Defined: operands are two's complement.
  - Magnitudes are divided. The quotient is truncated toward zero.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0 (wraps, no flag).
- Undefined: unsigned only. No sign logic is synthesized.
- Latency is identical in both builds.

## Test plan
- 100 / 7, with `start` pulsed once:
  - `busy` is high for 32 cycles.
  - `done` pulses exactly 32 clocks after the accepting edge.
  - `quotient`=14, `remainder`=2, `div_by_zero`=0.
- Unsigned build, 0xFFFFFFFF / 1 → `quotient`=0xFFFFFFFF, `remainder`=0. Then 5 / 9 → `quotient`=0, `remainder`=5.
- 1234 / 0 → after 32 clocks: `quotient`=0xFFFFFFFF, `remainder`=1234, `div_by_zero`=1.
- Signed build:
  - -7 / 2 → `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF.
  - 7 / -2 → `quotient`=0xFFFFFFFD, `remainder`=1.
  - 0x80000000 / -1 → `quotient`=0x80000000, `remainder`=0.
- 100 / 7 in flight, then disturbances:
  - `start` with 50 / 5 at iteration 5: ignored; the result is still 14 r 2.
  - New `start` in the `done` cycle with 50 / 5 → accepted; result 10 r 0 arrives 32 clocks later.
- `clear` at iteration 10 of 100 / 7:
  - Next cycle: `busy`=0 and all outputs are 0.
  - No `done` pulse appears within the following 40 clocks.

Source files
------------

// File: rtl/sequential_divider.sv
// Restoring sequential divider: one quotient bit per clock, BITS clocks per divide.
// Define SEQUENTIAL_DIVIDER_SIGNED_EN for two's-complement operands (same latency).
module sequential_divider #(
    parameter int unsigned BITS = 32
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            start,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            div_by_zero
);

    localparam int unsigned CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BITS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load;
    logic              w_step;
    logic              w_finish;

    logic [CNT_W-1:0]  r_cnt;
    logic [BITS-1:0]   r_rem;
    logic [BITS-1:0]   r_quo;
    logic [BITS-1:0]   r_dvs;
    logic              r_busy;
    logic              r_done;
    logic [BITS-1:0]   r_quotient;
    logic [BITS-1:0]   r_remainder;
    logic              r_div_by_zero;

    logic [BITS:0]     w_rem_sh;
    logic [BITS:0]     w_diff;
    logic [BITS-1:0]   w_rem_nxt;
    logic [BITS-1:0]   w_quo_nxt;
    logic              w_dvs_zero;
    logic [BITS-1:0]   w_dvd_mag;
    logic [BITS-1:0]   w_dvs_mag;
    logic [BITS-1:0]   w_q_fin;
    logic [BITS-1:0]   w_r_fin;

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST_ITER) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One restoring step: the partial remainder is always below the divisor,
    // so the BITS+1-bit difference's MSB is its sign.
    always_comb begin
        w_rem_sh  = {r_rem, r_quo[BITS-1]};
        w_diff    = w_rem_sh - {1'b0, r_dvs};
        w_rem_nxt = w_diff[BITS] ? w_rem_sh[BITS-1:0] : w_diff[BITS-1:0];
        w_quo_nxt = {r_quo[BITS-2:0], ~w_diff[BITS]};
    end

    assign w_dvs_zero = (r_dvs == '0);

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_mag = dividend[BITS-1] ? BITS'(-dividend) : dividend;
    assign w_dvs_mag = divisor[BITS-1]  ? BITS'(-divisor)  : divisor;
    // Divide-by-zero keeps the natural (unsigned) result
    assign w_q_fin   = (r_neg_q && !w_dvs_zero) ? BITS'(-w_quo_nxt) : w_quo_nxt;
    assign w_r_fin   = (r_neg_r && !w_dvs_zero) ? BITS'(-w_rem_nxt) : w_rem_nxt;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_load) begin
            r_neg_q <= dividend[BITS-1] ^ divisor[BITS-1];
            r_neg_r <= dividend[BITS-1];
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
    assign w_q_fin   = w_quo_nxt;
    assign w_r_fin   = w_rem_nxt;
`endif

    // State register, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= w_finish;
            if (w_load) begin
                r_rem <= '0;
                r_quo <= w_dvd_mag;
                r_dvs <= w_dvs_mag;
                r_cnt <= '0;
            end else if (w_step) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= w_finish ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                r_quotient    <= w_q_fin;
                r_remainder   <= w_r_fin;
                r_div_by_zero <= w_dvs_zero;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: vector table + scoreboard,
// plus hand sequences for ignored start, back-to-back start and mid-run clear.
module tb_sequential_divider;

    localparam int unsigned BITS = 32;
    localparam int LAT = 32;

    logic            clk;
    logic            clear;
    logic            start;
    logic [BITS-1:0] dividend;
    logic [BITS-1:0] divisor;
    logic            busy;
    logic            done;
    logic [BITS-1:0] quotient;
    logic [BITS-1:0] remainder;
    logic            div_by_zero;

    sequential_divider #(.BITS(BITS)) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BITS-1:0] dvd;
        logic [BITS-1:0] dvs;
        logic [BITS-1:0] q;
        logic [BITS-1:0] r;
        logic            dbz;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [BITS-1:0] dvd, input logic [BITS-1:0] dvs,
                           input logic [BITS-1:0] q, input logic [BITS-1:0] r, input logic dbz);
        vec_t v;
        v.dvd = dvd; v.dvs = dvs; v.q = q; v.r = r; v.dbz = dbz;
        vecs.push_back(v);
    endtask

    // Drive a start pulse for one edge and record its expected result
    task automatic issue(input vec_t v);
        start    = 1'b1;
        dividend = v.dvd;
        divisor  = v.dvs;
        sb.push_back(v);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge; poke>=0 drives start (50/5) while busy
    task automatic finish_op(input string tag, input int poke);
        int   lat;
        int   busy_cnt;
        bit   seen;
        vec_t e;
        lat = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && lat < LAT + 8) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (lat == poke) begin
                    start = 1'b1; dividend = 50; divisor = 5;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, BITS'(lat), BITS'(LAT));
        check({tag, " busy_cycles"}, BITS'(busy_cnt), BITS'(LAT));
        check({tag, " busy_at_done"}, BITS'(busy), BITS'(0));
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            if (seen) begin
                check({tag, " quotient"}, quotient, e.q);
                check({tag, " remainder"}, remainder, e.r);
                check({tag, " div_by_zero"}, BITS'(div_by_zero), BITS'(e.dbz));
            end
        end
    endtask

    initial begin
        vec_t v;
        int   dones;

        clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;

        // Vector table
        add_vec(32'd100,  32'd7, 32'd14,        32'd2,    1'b0);
        add_vec(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
        add_vec(32'd0,    32'd5, 32'd0,         32'd0,    1'b0);
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
        add_vec(-32'sd7,       32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        add_vec(32'd7,         -32'sd2,      32'hFFFF_FFFD, 32'd1,         1'b0);
        add_vec(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0);
        add_vec(-32'sd100,     -32'sd7,      32'd14,        -32'sd2,       1'b0);
`else
        add_vec(32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0);
        add_vec(32'd5,         32'd9,         32'd0,         32'd5,         1'b0);
        add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
        add_vec(32'h8000_0000, 32'd3,         32'd715827882, 32'd2,         1'b0);
        add_vec(32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            v.dvd = $urandom;
            v.dvs = $urandom >> $urandom_range(0, 31);
            if (i == 5) v.dvs = '0;
            if (v.dvs == '0) begin
                v.q = '1; v.r = v.dvd; v.dbz = 1'b1;
            end else begin
                v.q = v.dvd / v.dvs; v.r = v.dvd % v.dvs; v.dbz = 1'b0;
            end
            vecs.push_back(v);
        end
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", BITS'(busy), BITS'(0));
        check("reset done", BITS'(done), BITS'(0));
        check("reset quotient", quotient, BITS'(0));
        check("reset remainder", remainder, BITS'(0));
        check("reset div_by_zero", BITS'(div_by_zero), BITS'(0));
        clear = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i]);
            finish_op($sformatf("vec%0d", i), -1);
            @(posedge clk); #1;
        end

        // 100/7 with a start (50/5) during iteration 5: ignored
        v.dvd = 100; v.dvs = 7; v.q = 14; v.r = 2; v.dbz = 1'b0;
        issue(v);
        finish_op("ignored_start", 5);

        // Start in the done cycle is accepted
        v.dvd = 50; v.dvs = 5; v.q = 10; v.r = 0; v.dbz = 1'b0;
        issue(v);
        check("b2b done_dropped", BITS'(done), BITS'(0));
        check("b2b busy_rose", BITS'(busy), BITS'(1));
        finish_op("b2b", -1);
        @(posedge clk); #1;

        // Clear at iteration 10 aborts the operation
        start = 1'b1; dividend = 100; divisor = 7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear busy", BITS'(busy), BITS'(0));
        check("clear done", BITS'(done), BITS'(0));
        check("clear quotient", quotient, BITS'(0));
        check("clear remainder", remainder, BITS'(0));
        check("clear div_by_zero", BITS'(div_by_zero), BITS'(0));
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("clear no_done", BITS'(dones), BITS'(0));
        check("clear quotient_held", quotient, BITS'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
